// File: rtl/pwm_gen_mc_if.sv
// Control/status bundle for the multi-channel PWM/FM generator.
// The slave modport is the generator side; the master modport is the controller side.
interface pwm_gen_mc_if #(
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 8,
    parameter int unsigned PW = 8
);
    logic              run_ctrl;
    logic [PW-1:0]     presc;
    logic [CH-1:0]     ch_oen;
    logic [CH-1:0]     ch_mod;
    logic [CH*CW-1:0]  ch_width;
    logic [CH-1:0]     ch_pol;
    logic [CH-1:0]     pwm_out;
    logic [CH-1:0]     ch_active;
    logic [CH-1:0]     period_end;

    modport slave (
        input  run_ctrl, presc, ch_oen, ch_mod, ch_width, ch_pol,
        output pwm_out, ch_active, period_end
    );

    modport master (
        output run_ctrl, presc, ch_oen, ch_mod, ch_width, ch_pol,
        input  pwm_out, ch_active, period_end
    );
endinterface

// File: rtl/pwm_gen_mc.sv
// CH independent PWM/FM channels sharing one prescaler; width and mode
// are double-buffered and reload only at each channel's period boundary.
module pwm_gen_mc #(
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 8,
    parameter int unsigned PW = 8
) (
    input  logic       clk,
    input  logic       rst,
    pwm_gen_mc_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CW-1:0] ALL_ONES = '1;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [CW-1:0] count_q [CH];
    logic [CW-1:0] count_d [CH];
    logic [CW-1:0] width_q [CH];
    logic [CW-1:0] width_d [CH];
    logic [CH-1:0] mod_q, mod_d;
    logic [CH-1:0] raw_q, raw_d;
    logic [CH-1:0] pend_q, pend_d;
    logic [CH-1:0] bnd;
    logic [CH-1:0] active;

    // Shared prescaler; >= keeps a shrinking divisor from skipping the wrap
    always_comb begin
        tick   = bus.run_ctrl & (pcnt_q >= bus.presc);
        pcnt_d = pcnt_q;
        if (tick)
            pcnt_d = '0;
        else if (bus.run_ctrl)
            pcnt_d = pcnt_q + PW'(1);
    end

    // Per-channel next-state and output logic
    always_comb begin
        mod_d  = mod_q;
        raw_d  = raw_q;
        pend_d = '0;
        bnd    = '0;
        for (int i = 0; i < int'(CH); i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            width_d[i] = width_q[i];
            case (state_q[i])
                IDLE: begin
                    count_d[i] = '0;
                    raw_d[i]   = 1'b1;
                    if (!bus.ch_oen[i]) begin
                        state_d[i] = RUN;
                        width_d[i] = bus.ch_width[i*CW +: CW];
                        mod_d[i]   = bus.ch_mod[i];
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (mod_q[i]) begin
                            count_d[i] = count_q[i] + CW'(1);
                            if (count_q[i] == ALL_ONES) begin
                                bnd[i]   = 1'b1;
                                raw_d[i] = 1'b1;
                            end else if (count_q[i] == width_q[i]) begin
                                raw_d[i] = 1'b0;
                            end
                        end else if (count_q[i] == width_q[i]) begin
                            bnd[i]     = 1'b1;
                            count_d[i] = '0;
                            raw_d[i]   = ~raw_q[i];
                        end else begin
                            count_d[i] = count_q[i] + CW'(1);
                        end
                    end
                    if (bnd[i]) begin
                        width_d[i] = bus.ch_width[i*CW +: CW];
                        mod_d[i]   = bus.ch_mod[i];
                        pend_d[i]  = 1'b1;
                        // Graceful stop only ever lands on a boundary
                        if (bus.ch_oen[i]) begin
                            state_d[i] = IDLE;
                            count_d[i] = '0;
                            raw_d[i]   = 1'b1;
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
            mod_q  <= '1;
            raw_q  <= '1;
            pend_q <= '0;
            for (int i = 0; i < int'(CH); i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
                width_q[i] <= '0;
            end
        end else begin
            pcnt_q <= pcnt_d;
            mod_q  <= mod_d;
            raw_q  <= raw_d;
            pend_q <= pend_d;
            for (int i = 0; i < int'(CH); i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                width_q[i] <= width_d[i];
            end
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < int'(CH); i++)
            active[i] = (state_q[i] == RUN);
    end

    // Polarity is applied combinationally so it also takes effect during reset
    assign bus.pwm_out    = raw_q ^ bus.ch_pol;
    assign bus.ch_active  = active;
    assign bus.period_end = pend_q;
endmodule

// File: doc/pwm_gen_mc.md
Name: pwm_gen_mc

Overview:
Multi-channel successor to the single-channel PWM/FM generator. It provides CH independent channels behind one shared programmable prescaler. Each channel has its own mode, width, polarity and graceful enable. Width and mode are double-buffered: new values take effect only at a period boundary. The block sits in the system_code control path and drives output pins or drivers directly.

Parameters:
CH, 4, number of channels (1..16)
CW, 8, counter/width bit width per channel (4..16)
PW, 8, prescaler register width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous active-low reset
run_ctrl  in  1  global run enable; low freezes prescaler and all channel counters/outputs
presc  in  PW  tick divisor; one tick every presc+1 run_ctrl-qualified clocks
ch_oen  in  CH  per-channel disable request; 1=stop (graceful), 0=run
ch_mod  in  CH  per-channel mode; 0=FM, 1=PWM
ch_width  in  CH*CW  packed widths; channel i uses bits [i*CW +: CW]
ch_pol  in  CH  per-channel output inversion
pwm_out  out  CH  channel outputs
ch_active  out  CH  1 while the channel is in RUN
period_end  out  CH  one-clk pulse per completed period/half-period

Behaviour:
- Reset (async, rst=0):
  - pcnt=0; per channel state=IDLE, count=0, width_s=0, mod_s=1, out_raw=1, period_end=0.
  - pwm_out = out_raw ^ ch_pol, so it is all-ones for pol=0. ch_active=0.
  - Asserting reset mid-operation returns everything to these values immediately.
- Prescaler:
  - tick = run_ctrl & (pcnt >= presc).
  - On tick, pcnt<=0. Otherwise, if run_ctrl, pcnt<=pcnt+1. If run_ctrl=0, pcnt holds.
  - The >= compare guarantees that shrinking presc mid-count cannot skip wrap.
  - presc=0 gives a tick on every run_ctrl clock.
- Channel FSM (per channel, all channels identical and independent):
  - IDLE:
    - count=0, out_raw=1.
    - When ch_oen[i]=0 is sampled on any clk (not tick- or run_ctrl-gated), go to RUN.
    - On that same edge: width_s<=ch_width[i], mod_s<=ch_mod[i], count<=0, out_raw<=1.
  - RUN, PWM (mod_s=1):
    - On tick, count<=count+1; when count is all-ones, it wraps to 0. The wrap is the boundary.
    - On a tick with count==width_s and not all-ones, out_raw<=0.
    - At the boundary, out_raw<=1.
    - If the width compare and the boundary coincide (width_s = all-ones), the boundary wins and the output stays high (100% duty).
    - High time = (width_s+1) ticks; period = 2^CW ticks. width_s=0 gives 1 tick high.
  - RUN, FM (mod_s=0):
    - On tick, if count==width_s: count<=0, out_raw toggles, and this is the boundary.
    - Otherwise count<=count+1.
    - Half-period = width_s+1 ticks.
  - At every boundary:
    - width_s<=ch_width[i], mod_s<=ch_mod[i], so a mode change restarts from count 0 next period.
    - period_end[i] pulses high for exactly one clk, registered (visible the clk after the boundary edge).
  - Graceful stop:
    - In RUN with ch_oen[i]=1 at a boundary edge: go to IDLE with out_raw<=1 and count<=0 on that edge.
    - ch_active falls on that edge; period_end still pulses.
    - Deasserting ch_oen before the boundary cancels the stop.
- ch_active[i] = (state==RUN).
- Widths mid-period: ch_width changes are ignored until the next boundary.

Test Plan:
1. Reset with ch_pol=4'h0, then ch_pol=4'h5 -> pwm_out=4'hF and then 4'hA; ch_active=0; period_end=0.
2. CW=8, presc=0, ch0 PWM, width=8'h3F, run_ctrl=1, ch_oen[0]=0 -> pwm_out[0] high 64 clk, low 192 clk, repeating every 256; period_end[0] pulses every 256 clk.
3. ch1 FM, width=9 -> pwm_out[1] toggles every 10 clk (period 20); width=8'hFF in PWM -> constant high, period_end still every 256.
4. ch0 PWM, width 8'h3F changed to 8'h7F at count 8'h20 -> current period high 64; following periods high 128.
5. ch0 running, ch_oen[0]=1 at count 8'h10 -> continues to 8'hFF; on wrap edge ch_active[0]=0, pwm_out[0]=1 held. Repeat with ch_oen pulsed back to 0 before wrap -> no stop.
6. presc=3, width=1 PWM, run_ctrl low for 5 clk mid-high phase -> high lasts 8+5=13 clk; presc reduced from 3 to 0 while pcnt=2 -> tick on next clk, no lockup.
